// File: rtl/spi_master_param_if.sv
// spi_master_param_if
//
// Purpose: bundles the host handshake and the SPI bus signals of
// spi_master_param into one port. Signal names are seen from the master's
// side: i_* flow into the master and o_* flow out of it.
//
// Parameters: DATA_W (word width), NUM_SS (slave-select lines),
//             DIV_W (clock-divider width), SEL_W (slave-index width)
//
// Signals:
//   i_start   transfer request, only looked at while o_busy is low
//   i_cpol    SCLK idle level
//   i_cpha    0: sample on leading edge, 1: sample on trailing edge
//   i_clkDiv  SCLK half-period is i_clkDiv+1 system clocks
//   i_ssSel   slave index (values >= NUM_SS select the last slave)
//   i_data    word to transmit
//   i_miso    serial data from the slave
//   o_mosi    serial data to the slave
//   o_sclk    serial clock
//   o_ss      active-low slave selects, bit i selects slave i
//   o_busy    transfer in progress
//   o_done    one-cycle completion pulse
//   o_rxData  last received word
//
// Modports: master (the SPI master itself), slave (the side driving it)
interface spi_master_param_if #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 3,
  parameter int DIV_W  = 8,
  parameter int SEL_W  = 2
);

  logic              i_start;
  logic              i_cpol;
  logic              i_cpha;
  logic [DIV_W-1:0]  i_clkDiv;
  logic [SEL_W-1:0]  i_ssSel;
  logic [DATA_W-1:0] i_data;
  logic              i_miso;
  logic              o_mosi;
  logic              o_sclk;
  logic [NUM_SS-1:0] o_ss;
  logic              o_busy;
  logic              o_done;
  logic [DATA_W-1:0] o_rxData;

  modport master (
    input  i_start, i_cpol, i_cpha, i_clkDiv, i_ssSel, i_data, i_miso,
    output o_mosi, o_sclk, o_ss, o_busy, o_done, o_rxData
  );

  modport slave (
    output i_start, i_cpol, i_cpha, i_clkDiv, i_ssSel, i_data, i_miso,
    input  o_mosi, o_sclk, o_ss, o_busy, o_done, o_rxData
  );

endinterface

// File: rtl/spi_master_param.sv
// spi_master_param
//
// Purpose: parameterised SPI master. SCLK is derived from the system clock
// through a programmable divider (half-period H = clkDiv+1 cycles), all four
// CPOL/CPHA modes are supported, and one word is exchanged per start
// handshake. A transfer walks IDLE -> SETUP -> XFER -> HOLD -> IDLE; BUSY
// covers SETUP, XFER and HOLD, and DONE pulses for one cycle when HOLD ends.
//
// Ports:
//   i_clk   system clock, everything on the rising edge
//   i_rst   asynchronous active-high reset
//   bus     spi_master_param_if.master (handshake + SPI bus signals)
//
// Build option: define SPI_MASTER_LSB_FIRST_EN to shift LSB first on MOSI
// and to assemble received bits from the MSB side toward the LSB. Without it
// both directions are MSB first. Timing is the same either way.
module spi_master_param #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 3,
  parameter int DIV_W  = 8,
  parameter int SEL_W  = 2
) (
  input logic i_clk,
  input logic i_rst,
  spi_master_param_if.master bus
);

  localparam int EDGE_W = $clog2(2 * DATA_W);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } state_t;

  state_t            r_state;
  logic              r_armed;
  logic              r_cpol;
  logic              r_cpha;
  logic [DIV_W-1:0]  r_clkDiv;
  logic [SEL_W-1:0]  r_ssSel;
  logic [DATA_W-1:0] r_shift;
  logic [DIV_W-1:0]  r_divCnt;
  logic [EDGE_W-1:0] r_edgeCnt;
  logic              r_mosi;
  logic              r_sclk;
  logic [NUM_SS-1:0] r_ss;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_rxData;

  int                w_ssIdx;
  logic [NUM_SS-1:0] w_ssMask;
  logic              w_txBit;
  logic [DATA_W-1:0] w_shiftIn;
  logic              w_intervalEnd;
  logic              w_sampleEdge;

  // The slave index is clamped to the last slave, then turned into a
  // one-cold select pattern so exactly one line goes low during a transfer.
  always_comb begin
    w_ssIdx  = (int'(r_ssSel) >= NUM_SS) ? NUM_SS - 1 : int'(r_ssSel);
    w_ssMask = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (i == w_ssIdx) w_ssMask[i] = 1'b0;
    end
  end

  // A single shift register carries both directions: the outgoing bit is
  // taken from one end while the sampled MISO bit enters at the other, so
  // after DATA_W samples the register holds exactly the received word.
`ifdef SPI_MASTER_LSB_FIRST_EN
  assign w_txBit   = r_shift[0];
  assign w_shiftIn = {bus.i_miso, r_shift[DATA_W-1:1]};
`else
  assign w_txBit   = r_shift[DATA_W-1];
  assign w_shiftIn = {r_shift[DATA_W-2:0], bus.i_miso};
`endif

  // Every timed phase is a whole number of H-cycle intervals. Even edge
  // counts are leading edges; the sampling edge is the leading one for
  // CPHA=0 and the trailing one for CPHA=1.
  assign w_intervalEnd = (r_divCnt == r_clkDiv);
  assign w_sampleEdge  = (r_edgeCnt[0] == r_cpha);

  // Transfer sequencer. START is captured together with the configuration
  // while idle and the transfer proper begins one cycle later, so BUSY and
  // the slave select appear on the edge after START was sampled. During
  // XFER, SCLK toggles at the end of each H-cycle interval; MISO is shifted
  // in on the same clock edge that moves SCLK to its sampling level, and
  // MOSI only moves on the opposite edges. CPHA=0 skips the drive after the
  // last sample so MOSI stays put through HOLD.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_armed   <= 1'b0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_clkDiv  <= '0;
      r_ssSel   <= '0;
      r_shift   <= '0;
      r_divCnt  <= '0;
      r_edgeCnt <= '0;
      r_mosi    <= 1'b0;
      r_sclk    <= 1'b0;
      r_ss      <= '1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rxData  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_divCnt  <= '0;
          r_edgeCnt <= '0;
          if (r_armed) begin
            r_armed <= 1'b0;
            r_state <= SETUP;
            r_busy  <= 1'b1;
            r_ss    <= w_ssMask;
            r_sclk  <= r_cpol;
            if (!r_cpha) r_mosi <= w_txBit;
          end else begin
            r_sclk <= bus.i_cpol;
            if (bus.i_start) begin
              r_armed  <= 1'b1;
              r_shift  <= bus.i_data;
              r_cpol   <= bus.i_cpol;
              r_cpha   <= bus.i_cpha;
              r_clkDiv <= bus.i_clkDiv;
              r_ssSel  <= bus.i_ssSel;
            end
          end
        end

        SETUP: begin
          if (w_intervalEnd) begin
            r_divCnt <= '0;
            r_state  <= XFER;
          end else begin
            r_divCnt <= r_divCnt + 1'b1;
          end
        end

        XFER: begin
          if (w_intervalEnd) begin
            r_divCnt <= '0;
            r_sclk   <= ~r_sclk;
            if (w_sampleEdge) begin
              r_shift <= w_shiftIn;
            end else if (r_edgeCnt != LAST_EDGE) begin
              r_mosi <= w_txBit;
            end
            if (r_edgeCnt == LAST_EDGE) begin
              r_edgeCnt <= '0;
              r_state   <= HOLD;
            end else begin
              r_edgeCnt <= r_edgeCnt + 1'b1;
            end
          end else begin
            r_divCnt <= r_divCnt + 1'b1;
          end
        end

        HOLD: begin
          if (w_intervalEnd) begin
            r_divCnt <= '0;
            r_state  <= IDLE;
            r_ss     <= '1;
            r_rxData <= r_shift;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
          end else begin
            r_divCnt <= r_divCnt + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_mosi   = r_mosi;
  assign bus.o_sclk   = r_sclk;
  assign bus.o_ss     = r_ss;
  assign bus.o_busy   = r_busy;
  assign bus.o_done   = r_done;
  assign bus.o_rxData = r_rxData;

endmodule
